handshake_fifo: RTL

- Parametrised successor to the single-register valid/ready handshake block: a DEPTH-entry elastic buffer between a source (s_*) and a sink (m_*) channel, both using AXI-style valid/ready.
- Used as the standard channel buffer in front of AXI4 slave/master channel logic (AW/W/B/AR/R).
- Adds occupancy reporting, an almost-full flag and a synchronous flush.
- No combinational path from m_ready to s_ready, or from s_valid to m_valid.

---
 rtl/handshake_fifo_pkg.sv | 23 ++
 rtl/handshake_fifo_mem.sv | 39 +++
 rtl/handshake_fifo.sv | 102 ++++++++++
 3 files changed

// File: rtl/handshake_fifo_pkg.sv
// Shared types for the handshake FIFO: occupancy classification of the buffer
// and a helper that derives it from empty/full conditions.
package handshake_fifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    function automatic occ_state_e occ_decode(input logic is_empty, input logic is_full);
        occ_state_e occ;
        if (is_empty) begin
            occ = OCC_EMPTY;
        end else if (is_full) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_PARTIAL;
        end
        return occ;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DATA_WIDTH flop storage for the handshake FIFO: one write port,
// asynchronously cleared, and a purely combinational read mux.
module handshake_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/handshake_fifo.sv
// Elastic valid/ready buffer of DEPTH entries with occupancy count, almost-full
// flag and synchronous flush; all handshake outputs come from registered state.
module handshake_fifo
    import handshake_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    parameter  int AF_LEVEL   = 3,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [AW:0]           count,
    output logic                  almost_full
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW + 1)'(AF_LEVEL);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          almost_full_q, almost_full_d;
    occ_state_e    occ_q, occ_d;

    logic push;
    logic pop;
    logic wr_en;

    // Handshakes use only the registered occupancy, so no input-to-output paths.
    assign s_ready = (occ_q != OCC_FULL);
    assign m_valid = (occ_q != OCC_EMPTY);
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign wr_en   = push && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        occ_d         = occ_decode(count_d == '0, count_d == DEPTH_CNT);
        almost_full_d = (count_d >= AF_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            occ_q         <= OCC_EMPTY;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            occ_q         <= occ_d;
        end
    end

    assign count       = count_q;
    assign almost_full = almost_full_q;

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .rd_addr (rd_ptr_q),
        .rd_data (m_data)
    );

endmodule
